axi_slave_ram: RTL and testbench

Synthesizable single-clock AXI4 slave memory responder: accepts write bursts on AW/W, stores them into an internal dual-port RAM, and returns B responses; accepts read bursts on AR and returns R data. It is the far-end target for the master port of the AXI data-width converter, so converted traffic lands on a real RAM rather than only a bench model.

---
 rtl/axi_slave_ram.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi_slave_ram.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: single-clock AXI4 slave that stores write bursts into an
// internal RAM and serves read bursts from it. The write and read engines are
// independent; the RAM has one write port and one registered read port.
// Optional build macro: AXI_SLAVE_RAM_ERR_EN -- when defined, bursts whose start
// address lies above the RAM window get SLVERR (writes suppressed, reads zero).
//
// Handshakes: a transfer happens on the rising clock edge where valid and ready
// are both high; once this block raises a valid it holds it, with a stable
// payload, until that edge.
module axi_slave_ram #(
    parameter int AW     = 64,
    parameter int IW     = 12,
    parameter int DW     = 64,
    parameter int MEM_AW = 10
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_arst,
    input  logic [IW-1:0]     s_axi_awid,
    input  logic [AW-1:0]     s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DW-1:0]     s_axi_wdata,
    input  logic [DW/8-1:0]   s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [IW-1:0]     s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [IW-1:0]     s_axi_arid,
    input  logic [AW-1:0]     s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [IW-1:0]     s_axi_rid,
    output logic [DW-1:0]     s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [1:0]        dbg_wr_state_o,
    output logic [1:0]        dbg_rd_state_o
);

    localparam int              SB  = $clog2(DW/8);
    localparam int              NB  = DW/8;
    localparam logic [2:0]      SB3 = 3'(SB);
    localparam logic [AW-1:0]   ONE = AW'(1);
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rd_state_e;

    // Beats wider than the data bus are handled as full-width beats.
    function automatic logic [2:0] clamp_size(input logic [2:0] sz);
        return (sz > SB3) ? SB3 : sz;
    endfunction

    // Address of the following beat: FIXED holds, WRAP folds inside the
    // (len+1)<<size window, everything else (INCR, reserved) increments.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                                input logic [2:0]    size,
                                                input logic [7:0]    len,
                                                input logic [1:0]    burst);
        logic [AW-1:0] nb;
        logic [AW-1:0] incr;
        logic [AW-1:0] wmask;
        logic          wrap_ok;
        nb      = ONE << size;
        incr    = (addr & ~(nb - ONE)) + nb;
        wmask   = ((AW'(len) + ONE) << size) - ONE;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        if (burst == 2'b00) begin
            return addr;
        end else if (burst == 2'b10 && wrap_ok) begin
            return (addr & ~wmask) | (incr & wmask);
        end else begin
            return incr;
        end
    endfunction

    logic [DW-1:0] mem_q [0:(1<<MEM_AW)-1];

    wr_state_e     wr_state_q, wr_state_d;
    logic [IW-1:0] wid_q, wid_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    wlen_q, wlen_d;
    logic [2:0]    wsize_q, wsize_d;
    logic [1:0]    wburst_q, wburst_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          werr_q, werr_d;

    rd_state_e     rd_state_q, rd_state_d;
    logic [IW-1:0] rid_q, rid_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [7:0]    rlen_q, rlen_d;
    logic [2:0]    rsize_q, rsize_d;
    logic [1:0]    rburst_q, rburst_d;
    logic [7:0]    rcnt_q, rcnt_d;
    logic          rerr_q, rerr_d;
    logic [DW-1:0] rdata_q;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_oor, ar_oor;
    logic [MEM_AW-1:0] widx, ridx;
    logic unused_wlast;

    // Burst length comes from awlen; wlast carries no control meaning here.
    assign unused_wlast = s_axi_wlast;

`ifdef AXI_SLAVE_RAM_ERR_EN
    assign aw_oor = |(s_axi_awaddr >> (SB + MEM_AW));
    assign ar_oor = |(s_axi_araddr >> (SB + MEM_AW));
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    assign widx = waddr_q[SB +: MEM_AW];
    assign ridx = raddr_q[SB +: MEM_AW];

    assign s_axi_awready = (wr_state_q == W_IDLE) && !s_axi_arst;
    assign s_axi_wready  = (wr_state_q == W_DATA) && !s_axi_arst;
    assign s_axi_bvalid  = (wr_state_q == W_RESP) && !s_axi_arst;
    assign s_axi_bid     = wid_q;
    assign s_axi_bresp   = werr_q ? RESP_SLVERR : RESP_OKAY;

    assign s_axi_arready = (rd_state_q == R_IDLE) && !s_axi_arst;
    assign s_axi_rvalid  = (rd_state_q == R_DATA) && !s_axi_arst;
    assign s_axi_rlast   = s_axi_rvalid && (rcnt_q == rlen_q);
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rerr_q ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs = s_axi_awready && s_axi_awvalid;
    assign w_hs  = s_axi_wready  && s_axi_wvalid;
    assign b_hs  = s_axi_bvalid  && s_axi_bready;
    assign ar_hs = s_axi_arready && s_axi_arvalid;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    assign dbg_wr_state_o = wr_state_q;
    assign dbg_rd_state_o = rd_state_q;

    // Write engine next state: latch AW, count W beats, then offer B.
    always_comb begin
        wr_state_d = wr_state_q;
        wid_d      = wid_q;
        waddr_d    = waddr_q;
        wlen_d     = wlen_q;
        wsize_d    = wsize_q;
        wburst_d   = wburst_q;
        wcnt_d     = wcnt_q;
        werr_d     = werr_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    wid_d      = s_axi_awid;
                    waddr_d    = s_axi_awaddr;
                    wlen_d     = s_axi_awlen;
                    wsize_d    = clamp_size(s_axi_awsize);
                    wburst_d   = s_axi_awburst;
                    wcnt_d     = 8'd0;
                    werr_d     = aw_oor;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (wcnt_q == wlen_q) begin
                        wr_state_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Write engine state register; reset abandons any burst in flight.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_arst) begin
            wr_state_q <= W_IDLE;
            wid_q      <= '0;
            waddr_q    <= '0;
            wlen_q     <= '0;
            wsize_q    <= '0;
            wburst_q   <= '0;
            wcnt_q     <= '0;
            werr_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wid_q      <= wid_d;
            waddr_q    <= waddr_d;
            wlen_q     <= wlen_d;
            wsize_q    <= wsize_d;
            wburst_q   <= wburst_d;
            wcnt_q     <= wcnt_d;
            werr_q     <= werr_d;
        end
    end

    // RAM write port: byte lanes enabled by wstrb; out-of-range bursts write nothing.
    always_ff @(posedge s_axi_aclk) begin
        if (w_hs && !werr_q) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem_q[widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read engine next state: latch AR, alternate fetch and present per beat.
    always_comb begin
        rd_state_d = rd_state_q;
        rid_d      = rid_q;
        raddr_d    = raddr_q;
        rlen_d     = rlen_q;
        rsize_d    = rsize_q;
        rburst_d   = rburst_q;
        rcnt_d     = rcnt_q;
        rerr_d     = rerr_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rid_d      = s_axi_arid;
                    raddr_d    = s_axi_araddr;
                    rlen_d     = s_axi_arlen;
                    rsize_d    = clamp_size(s_axi_arsize);
                    rburst_d   = s_axi_arburst;
                    rcnt_d     = 8'd0;
                    rerr_d     = ar_oor;
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rcnt_q == rlen_q) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rcnt_d     = rcnt_q + 8'd1;
                        raddr_d    = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
                        rd_state_d = R_FETCH;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read engine state register.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_arst) begin
            rd_state_q <= R_IDLE;
            rid_q      <= '0;
            raddr_q    <= '0;
            rlen_q     <= '0;
            rsize_q    <= '0;
            rburst_q   <= '0;
            rcnt_q     <= '0;
            rerr_q     <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rid_q      <= rid_d;
            raddr_q    <= raddr_d;
            rlen_q     <= rlen_d;
            rsize_q    <= rsize_d;
            rburst_q   <= rburst_d;
            rcnt_q     <= rcnt_d;
            rerr_q     <= rerr_d;
        end
    end

    // Registered RAM read port, loaded in R_FETCH and held through R_DATA;
    // a same-cycle write to the same word is not visible (old data returned).
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_arst) begin
            rdata_q <= '0;
        end else if (rd_state_q == R_FETCH) begin
            rdata_q <= rerr_q ? '0 : mem_q[ridx];
        end
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: randomized scoreboard bench for axi_slave_ram with a
// word-array memory model and AXI beat addresses computed from burst rules.
module tb_axi_slave_ram;

  localparam int AW = 64;
  localparam int IW = 12;
  localparam int DW = 64;
  localparam int MEM_AW = 10;
  localparam int DEPTH = 1 << MEM_AW;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  logic clk;
  logic s_axi_arst;
  logic [IW-1:0] s_axi_awid;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0] s_axi_awlen;
  logic [2:0] s_axi_awsize;
  logic [1:0] s_axi_awburst;
  logic s_axi_awvalid, s_axi_awready;
  logic [DW-1:0] s_axi_wdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [IW-1:0] s_axi_bid;
  logic [1:0] s_axi_bresp;
  logic s_axi_bvalid, s_axi_bready;
  logic [IW-1:0] s_axi_arid;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0] s_axi_arlen;
  logic [2:0] s_axi_arsize;
  logic [1:0] s_axi_arburst;
  logic s_axi_arvalid, s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0] s_axi_rresp;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [1:0] dbg_wr_state, dbg_rd_state;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic [DW-1:0] beat_data [16];
  logic [7:0]    beat_strb [16];
  logic [IW+1:0] exp_b [$];
  r_exp_t        exp_r [$];

  int bp_mode = 0;
  bit r_hold = 0;
  bit b_hold = 0;
  bit b_wait = 0;
  bit r_wait = 0;

  axi_slave_ram #(.AW(AW), .IW(IW), .DW(DW), .MEM_AW(MEM_AW)) dut (
    .s_axi_aclk(clk), .s_axi_arst(s_axi_arst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .dbg_wr_state_o(dbg_wr_state), .dbg_rd_state_o(dbg_rd_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  function automatic int word_index(input logic [63:0] a);
    return int'((a / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic bit out_of_range(input logic [63:0] a);
`ifdef AXI_SLAVE_RAM_ERR_EN
    return (a / 64'(8 * DEPTH)) != 64'd0;
`else
    return (a != a);
`endif
  endfunction

  // Address of beat n of a burst, straight from the AXI burst definitions.
  function automatic logic [63:0] beat_addr(input logic [63:0] start, input logic [63:0] nb,
                                            input int len, input logic [1:0] burst, input int n);
    logic [63:0] aligned, wsize, lower, a;
    if (burst == 2'b00 || n == 0) return start;
    aligned = start - (start % nb);
    a = aligned + 64'(n) * nb;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wsize = 64'(len + 1) * nb;
      lower = start - (start % wsize);
      if (a >= lower + wsize) a = a - wsize;
    end
    return a;
  endfunction

  function automatic void model_write(input int idx, input logic [DW-1:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++) begin
      if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
    end
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- ready drivers ----------------
  initial begin
    s_axi_bready = 1'b0;
    s_axi_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s_axi_bready = b_hold ? 1'b0 : ((bp_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
      s_axi_rready = r_hold ? 1'b0 : ((bp_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (s_axi_arst) begin
      b_wait = 0;
    end else begin
      if (s_axi_bvalid) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 128'(s_axi_bvalid), 128'd0);
        end else begin
          check("bid", 128'(s_axi_bid), 128'(exp_b[0][IW+1:2]));
          check("bresp", 128'(s_axi_bresp), 128'(exp_b[0][1:0]));
          if (s_axi_bready) void'(exp_b.pop_front());
        end
      end else if (b_wait) begin
        check("bvalid_held", 128'(s_axi_bvalid), 128'd1);
      end
      b_wait = s_axi_bvalid && !s_axi_bready;
    end
  end

  always @(negedge clk) begin
    if (s_axi_arst) begin
      r_wait = 0;
    end else begin
      if (s_axi_rvalid) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 128'(s_axi_rvalid), 128'd0);
        end else begin
          check("rid", 128'(s_axi_rid), 128'(exp_r[0].id));
          check("rdata", 128'(s_axi_rdata), 128'(exp_r[0].data));
          check("rresp", 128'(s_axi_rresp), 128'(exp_r[0].resp));
          check("rlast", 128'(s_axi_rlast), 128'(exp_r[0].last));
          if (s_axi_rready) void'(exp_r.pop_front());
        end
      end else if (r_wait) begin
        check("rvalid_held", 128'(s_axi_rvalid), 128'd1);
      end
      r_wait = s_axi_rvalid && !s_axi_rready;
    end
  end

  // ---------------- driver tasks ----------------
  // Holds the current valid until the matching ready is seen; returns at posedge+1.
  task automatic wait_ready(input int ch);
    int g;
    bit rdy;
    g = 0;
    do begin
      @(negedge clk);
      case (ch)
        0: rdy = s_axi_awready;
        1: rdy = s_axi_wready;
        default: rdy = s_axi_arready;
      endcase
      @(posedge clk);
      #1;
      g++;
    end while (!rdy && g < 200);
    if (!rdy) check("ready_timeout", 128'(ch), 128'hFF);
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [63:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] nb;
    bit err;
    int g;
    nb = 64'd1 << ((size > 3'd3) ? 3'd3 : size);
    err = out_of_range(addr);
    for (int n = 0; n <= len; n++) begin
      if (!err) model_write(word_index(beat_addr(addr, nb, len, burst, n)), beat_data[n], beat_strb[n]);
    end
    exp_b.push_back({id, err ? 2'b10 : 2'b00});
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    wait_ready(0);
    s_axi_awvalid = 1'b0;
    @(negedge clk);
    check("w_latency", 128'(s_axi_wready), 128'd1);
    @(posedge clk);
    #1;
    for (int n = 0; n <= len; n++) begin
      if (bp_mode != 0 && $urandom_range(0, 2) == 0) begin
        s_axi_wvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_axi_wvalid = 1'b1; s_axi_wdata = beat_data[n];
      s_axi_wstrb = beat_strb[n]; s_axi_wlast = (n == len);
      wait_ready(1);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    @(negedge clk);
    check("b_latency", 128'(s_axi_bvalid), 128'd1);
    g = 0;
    do begin @(posedge clk); #2; g++; end while (exp_b.size() != 0 && g < 300);
    if (exp_b.size() != 0) begin
      check("b_timeout", 128'(exp_b.size()), 128'd0);
      exp_b.delete();
    end
    @(negedge clk);
    check("aw_reaccept", 128'(s_axi_awready), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [63:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] nb;
    bit err;
    int g;
    r_exp_t e;
    nb = 64'd1 << ((size > 3'd3) ? 3'd3 : size);
    err = out_of_range(addr);
    for (int n = 0; n <= len; n++) begin
      e.id = id;
      e.data = err ? '0 : model_mem[word_index(beat_addr(addr, nb, len, burst, n))];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (n == len);
      exp_r.push_back(e);
    end
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    wait_ready(2);
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    check("r_fetch_gap", 128'(s_axi_rvalid), 128'd0);
    @(negedge clk);
    check("r_latency", 128'(s_axi_rvalid), 128'd1);
    g = 0;
    do begin @(posedge clk); #2; g++; end while (exp_r.size() != 0 && g < 600);
    if (exp_r.size() != 0) begin
      check("r_timeout", 128'(exp_r.size()), 128'd0);
      exp_r.delete();
    end
    @(negedge clk);
    check("ar_reaccept", 128'(s_axi_arready), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic fill_beats(input int len, input bit full_strb);
    for (int n = 0; n <= len; n++) begin
      beat_data[n] = {$urandom, $urandom};
      beat_strb[n] = full_strb ? 8'hFF : 8'($urandom_range(0, 255));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, 128'(s_axi_awready), 128'd0);
    check({tag, "_wready"}, 128'(s_axi_wready), 128'd0);
    check({tag, "_bvalid"}, 128'(s_axi_bvalid), 128'd0);
    check({tag, "_arready"}, 128'(s_axi_arready), 128'd0);
    check({tag, "_rvalid"}, 128'(s_axi_rvalid), 128'd0);
    check({tag, "_rlast"}, 128'(s_axi_rlast), 128'd0);
    check({tag, "_bid_bresp"}, 128'({s_axi_bid, s_axi_bresp}), 128'd0);
    check({tag, "_rid_rresp"}, 128'({s_axi_rid, s_axi_rresp}), 128'd0);
    check({tag, "_rdata"}, 128'(s_axi_rdata), 128'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    check("watchdog", 128'd1, 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] addr;
    int len;
    logic [1:0] burst;
    logic [2:0] size;
    s_axi_arst = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
    s_axi_awburst = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    s_axi_arst = 1'b0;
    @(negedge clk);
    check("post_reset_awready", 128'(s_axi_awready), 128'd1);
    check("post_reset_arready", 128'(s_axi_arready), 128'd1);
    @(posedge clk);
    #1;

    // Give every RAM word a defined value.
    for (int i = 0; i < DEPTH / 16; i++) begin
      fill_beats(15, 1'b1);
      do_write(12'(i), 64'(i * 128), 15, 3'd3, 2'b01);
    end

    // INCR write/readback of four full words.
    beat_data[0] = 64'h1111_1111_1111_1111; beat_data[1] = 64'h2222_2222_2222_2222;
    beat_data[2] = 64'h3333_3333_3333_3333; beat_data[3] = 64'h4444_4444_4444_4444;
    for (int n = 0; n < 4; n++) beat_strb[n] = 8'hFF;
    do_write(12'h5A5, 64'h100, 3, 3'd3, 2'b01);
    do_read(12'h3C3, 64'h100, 3, 3'd3, 2'b01);

    // Partial strobe merge.
    beat_data[0] = 64'h1111_1111_2222_2222; beat_strb[0] = 8'hFF;
    do_write(12'h001, 64'h40, 0, 3'd3, 2'b01);
    beat_data[0] = 64'hAAAA_AAAA_BBBB_BBBB; beat_strb[0] = 8'h0F;
    do_write(12'h002, 64'h40, 0, 3'd3, 2'b01);
    do_read(12'h003, 64'h40, 0, 3'd3, 2'b01);

    // WRAP read starting mid-window.
    fill_beats(3, 1'b1);
    do_write(12'h010, 64'h20, 3, 3'd3, 2'b01);
    do_read(12'h011, 64'h38, 3, 3'd3, 2'b10);

    // R backpressure for 10 cycles in the middle of a burst.
    fork
      do_read(12'h0C3, 64'h200, 7, 3'd3, 2'b01);
      begin
        int g;
        g = 0;
        while (!s_axi_rvalid && g < 100) begin @(negedge clk); g++; end
        @(posedge clk);
        @(negedge clk);
        r_hold = 1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        r_hold = 0;
      end
    join

    // B backpressure for 5 cycles.
    b_hold = 1;
    fill_beats(1, 1'b1);
    fork
      do_write(12'h0B5, 64'h300, 1, 3'd3, 2'b01);
      begin
        int g;
        g = 0;
        while (!s_axi_bvalid && g < 200) begin @(negedge clk); g++; end
        repeat (5) @(posedge clk);
        @(negedge clk);
        b_hold = 0;
      end
    join

    // Reset in the middle of an 8-beat write, after three beats.
    fill_beats(7, 1'b1);
    s_axi_awid = 12'h777; s_axi_awaddr = 64'h800; s_axi_awlen = 8'd7;
    s_axi_awsize = 3'd3; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    wait_ready(0);
    s_axi_awvalid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      model_write(word_index(64'h800 + 64'(n * 8)), beat_data[n], 8'hFF);
      s_axi_wvalid = 1'b1; s_axi_wdata = beat_data[n]; s_axi_wstrb = 8'hFF;
      wait_ready(1);
    end
    s_axi_wvalid = 1'b0;
    s_axi_arst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    @(posedge clk);
    #1;
    s_axi_arst = 1'b0;
    @(negedge clk);
    check("midburst_awready", 128'(s_axi_awready), 128'd1);
    check("midburst_wready", 128'(s_axi_wready), 128'd0);
    @(posedge clk);
    #1;
    fill_beats(3, 1'b1);
    do_write(12'h778, 64'h820, 3, 3'd3, 2'b01);
    do_read(12'h779, 64'h800, 7, 3'd3, 2'b01);

    // Address above the RAM window (aliases unless range checking is built in).
    fill_beats(1, 1'b1);
    do_write(12'h0E0, 64'h10000, 1, 3'd3, 2'b01);
    do_read(12'h0E1, 64'h0, 1, 3'd3, 2'b01);
    do_read(12'h0E2, 64'h10000, 1, 3'd3, 2'b01);

    // Randomized traffic with backpressure and gaps.
    bp_mode = 1;
    for (int k = 0; k < 80; k++) begin
      burst = 2'($urandom_range(0, 3));
      size = 3'($urandom_range(0, 5));
      if (burst == 2'b10) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end else begin
        len = $urandom_range(0, 15);
      end
      addr = 64'($urandom_range(0, 16'h3FFF));
      if ($urandom_range(0, 7) == 0) addr = addr + 64'h1_0000_0000;
      if (burst == 2'b10) addr = addr & ~((64'd1 << ((size > 3'd3) ? 3'd3 : size)) - 64'd1);
      if ($urandom_range(0, 1) == 0) begin
        fill_beats(len, 1'b0);
        do_write(12'($urandom), addr, len, size, burst);
      end else begin
        do_read(12'($urandom), addr, len, size, burst);
      end
    end
    bp_mode = 0;
    repeat (4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
